// File: rtl/button_conditioner.sv
// Push-button front end for the lighting block: synchronise, debounce, and turn each press
// into one-cycle step pulses, with auto-repeat while the button is held.
module button_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_PERIOD   = 8,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic button_raw,
  output logic button,
  output logic pressed,
  output logic repeat_active
);

  typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_REPEAT} state_t;

  localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CNT_W-1:0]       db_cnt;
  logic [CNT_W-1:0]       db_cnt_next;
  logic                   pressed_next;
  state_t                 state;
  state_t                 state_next;
  logic [CNT_W-1:0]       rcnt;
  logic [CNT_W-1:0]       rcnt_next;
  logic                   button_next;
  logic                   repeat_next;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], button_raw};
    end
  end

  // pressed_next is the level for the coming cycle; the FSM keys off it so the first
  // pulse lines up with the first cycle pressed is high.
  always_comb begin
    pressed_next = pressed;
    db_cnt_next  = db_cnt;
    if (s == pressed) begin
      db_cnt_next = '0;
    end else if (db_cnt >= DB_LAST) begin
      pressed_next = ~pressed;
      db_cnt_next  = '0;
    end else if (db_cnt != CNT_MAX) begin
      db_cnt_next = db_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt  <= '0;
      pressed <= 1'b0;
    end else begin
      db_cnt  <= db_cnt_next;
      pressed <= pressed_next;
    end
  end

  always_comb begin
    state_next  = state;
    rcnt_next   = rcnt;
    button_next = 1'b0;
    repeat_next = repeat_active;
    case (state)
      ST_IDLE: begin
        repeat_next = 1'b0;
        if (pressed_next && !pressed) begin
          button_next = 1'b1;
          rcnt_next   = '0;
          state_next  = ST_HELD;
        end
      end
      ST_HELD: begin
        if (!pressed_next) begin
          rcnt_next   = '0;
          repeat_next = 1'b0;
          state_next  = ST_IDLE;
        end else if ((REPEAT_DELAY > 0) && (rcnt == DELAY_LAST)) begin
          button_next = 1'b1;
          repeat_next = 1'b1;
          rcnt_next   = '0;
          state_next  = ST_REPEAT;
        end else if (rcnt != CNT_MAX) begin
          rcnt_next = rcnt + CNT_W'(1);
        end
      end
      ST_REPEAT: begin
        // Release takes priority over a pulse scheduled for the same cycle.
        if (!pressed_next) begin
          rcnt_next   = '0;
          repeat_next = 1'b0;
          state_next  = ST_IDLE;
        end else if (rcnt == PERIOD_LAST) begin
          button_next = 1'b1;
          rcnt_next   = '0;
        end else if (rcnt != CNT_MAX) begin
          rcnt_next = rcnt + CNT_W'(1);
        end
      end
      default: begin
        repeat_next = 1'b0;
        rcnt_next   = '0;
        state_next  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      rcnt          <= '0;
      button        <= 1'b0;
      repeat_active <= 1'b0;
    end else begin
      state         <= state_next;
      rcnt          <= rcnt_next;
      button        <= button_next;
      repeat_active <= repeat_next;
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: a window/arithmetic reference model predicts
// every cycle's outputs, and a negedge monitor compares them against the DUT.
module tb_button_conditioner;

  localparam int SYNC  = 2;
  localparam int DEB   = 4;
  localparam int DELAY = 16;
  localparam int PER   = 8;

  typedef struct {
    logic button;
    logic pressed;
    logic rep;
  } exp_t;

  logic clk;
  logic rst;
  logic button_raw;
  logic button;
  logic pressed;
  logic repeat_active;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];

  logic m_pipe[$];
  logic m_win[$];
  logic m_pressed;
  int   m_cyc;
  int   m_press_cyc;

  button_conditioner #(
    .SYNC_STAGES(SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY(DELAY),
    .REPEAT_PERIOD(PER),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .button_raw(button_raw),
    .button(button),
    .pressed(pressed),
    .repeat_active(repeat_active)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  // Reference model: pressed flips once the last DEB synchronised samples all disagree
  // with it; pulses follow from the number of cycles since the press.
  always @(posedge clk) begin
    exp_t e;
    logic s_now;
    logic all_differ;
    int   d;
    m_cyc++;
    if (rst) begin
      m_pipe = {};
      m_win  = {};
      for (int i = 0; i < SYNC; i++) m_pipe.push_back(1'b0);
      for (int i = 0; i < DEB; i++) m_win.push_back(1'b0);
      m_pressed = 1'b0;
      e.button  = 1'b0;
      e.pressed = 1'b0;
      e.rep     = 1'b0;
    end else begin
      s_now = m_pipe[SYNC-1];
      m_win.push_back(s_now);
      void'(m_win.pop_front());
      all_differ = 1'b1;
      foreach (m_win[i]) if (m_win[i] == m_pressed) all_differ = 1'b0;
      if (all_differ) begin
        m_pressed = ~m_pressed;
        if (m_pressed) m_press_cyc = m_cyc;
      end
      m_pipe.push_front(button_raw);
      void'(m_pipe.pop_back());
      e.pressed = m_pressed;
      e.button  = 1'b0;
      e.rep     = 1'b0;
      if (m_pressed) begin
        d = m_cyc - m_press_cyc;
        e.rep    = (DELAY > 0) && (d >= DELAY);
        e.button = (d == 0) || (e.rep && ((d - DELAY) % PER == 0));
      end
    end
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() == 0) begin
      checkOutput("scoreboard_underflow", 1'b1, 1'b0);
    end else begin
      e = exp_q.pop_front();
      checkOutput("pressed", pressed, e.pressed);
      checkOutput("button", button, e.button);
      checkOutput("repeat_active", repeat_active, e.rep);
    end
  end

  // Inputs change 2 time units after the falling edge, well clear of either edge.
  task automatic applyStimulus(input logic val, input int cycles);
    button_raw = val;
    repeat (cycles) begin
      @(negedge clk);
      #2;
    end
  endtask

  initial begin
    int len;
    logic val;
    rst        = 1'b1;
    button_raw = 1'b0;
    @(negedge clk);
    #2;
    for (int i = 0; i < 5; i++) applyStimulus(logic'(i % 2 == 0), 1);
    applyStimulus(1'b0, 1);
    rst = 1'b0;
    applyStimulus(1'b0, 4);

    applyStimulus(1'b1, 10);
    applyStimulus(1'b0, 12);

    applyStimulus(1'b1, 3);
    applyStimulus(1'b0, 10);

    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 1);
    applyStimulus(1'b1, 2);
    applyStimulus(1'b0, 1);
    applyStimulus(1'b1, 12);
    applyStimulus(1'b0, 12);

    applyStimulus(1'b1, 50);
    applyStimulus(1'b0, 12);

    applyStimulus(1'b1, 30);
    checkOutput("repeat_before_reset", repeat_active, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("async_rst_button", button, 1'b0);
    checkOutput("async_rst_pressed", pressed, 1'b0);
    checkOutput("async_rst_repeat", repeat_active, 1'b0);
    #1;
    applyStimulus(1'b1, 2);
    rst = 1'b0;
    applyStimulus(1'b1, 20);
    applyStimulus(1'b0, 12);

    for (int r = 0; r < 40; r++) begin
      val = logic'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) len = $urandom_range(1, 5);
      else len = $urandom_range(6, 40);
      applyStimulus(val, len);
    end
    applyStimulus(1'b0, 12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
